// File: rtl/soc_fpga_ram_arb_if.sv
// ---------------------------------------------------------------------------
// soc_fpga_ram_arb_if
// Bundle of the requester handshakes and the single-port RAM connection
// for soc_fpga_ram_arb.
//
// Parameters:
//   DATAWIDTH  RAM word width
//   ADDRWIDTH  RAM word-address width
//
// Signals:
//   Req0/Req1, We0/We1, Addr0/Addr1, WData0/WData1   requests
//   Gnt0/Gnt1                                        combinational grants
//   RValid0/RValid1, RData                           read return
//   RamAddr, RamDataIn, RamWe                        drive into the RAM
//   RamDataOut                                       read data from the RAM
//
// Optional (macro SOC_FPGA_RAM_ARB_PERF_EN):
//   PerfClr                                          synchronous counter clear
//   GntCnt0/GntCnt1, ConflictCnt                     performance counters
//
// Modports: slave = arbiter side, master = requester/RAM environment side.
// ---------------------------------------------------------------------------
interface soc_fpga_ram_arb_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 14
);

  logic                 Req0;
  logic                 Req1;
  logic                 We0;
  logic                 We1;
  logic [ADDRWIDTH-1:0] Addr0;
  logic [ADDRWIDTH-1:0] Addr1;
  logic [DATAWIDTH-1:0] WData0;
  logic [DATAWIDTH-1:0] WData1;
  logic                 Gnt0;
  logic                 Gnt1;
  logic                 RValid0;
  logic                 RValid1;
  logic [DATAWIDTH-1:0] RData;
  logic [ADDRWIDTH-1:0] RamAddr;
  logic [DATAWIDTH-1:0] RamDataIn;
  logic                 RamWe;
  logic [DATAWIDTH-1:0] RamDataOut;

`ifdef SOC_FPGA_RAM_ARB_PERF_EN
  logic                 PerfClr;
  logic [31:0]          GntCnt0;
  logic [31:0]          GntCnt1;
  logic [31:0]          ConflictCnt;

  modport slave (
    input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1,
    output Gnt0, Gnt1, RValid0, RValid1, RData,
    output RamAddr, RamDataIn, RamWe,
    input  RamDataOut,
    input  PerfClr,
    output GntCnt0, GntCnt1, ConflictCnt
  );

  modport master (
    output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1,
    input  Gnt0, Gnt1, RValid0, RValid1, RData,
    input  RamAddr, RamDataIn, RamWe,
    output RamDataOut,
    output PerfClr,
    input  GntCnt0, GntCnt1, ConflictCnt
  );
`else
  modport slave (
    input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1,
    output Gnt0, Gnt1, RValid0, RValid1, RData,
    output RamAddr, RamDataIn, RamWe,
    input  RamDataOut
  );

  modport master (
    output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1,
    input  Gnt0, Gnt1, RValid0, RValid1, RData,
    input  RamAddr, RamDataIn, RamWe,
    output RamDataOut
  );
`endif

endinterface

// File: rtl/soc_fpga_ram_arb.sv
// ---------------------------------------------------------------------------
// soc_fpga_ram_arb
// Two-requester arbiter in front of one single-port synchronous RAM
// (1-cycle read latency). Requester 0 is the CPU bus slave, requester 1 the
// debug/pattern loader. One transfer per cycle, fully back-to-back; each read
// returns a one-cycle RValid pulse to its owner with RData passed straight
// through from the RAM.
//
// Parameters:
//   DATAWIDTH  RAM word width
//   ADDRWIDTH  RAM word-address width
//   FIXED_PRI  0 = round-robin, 1 = requester 0 always wins
//
// Ports:
//   HCLK     system clock
//   HRESETn  asynchronous active-low reset
//   bus      soc_fpga_ram_arb_if.slave (requests, grants, read return, RAM)
//
// Optional feature, macro SOC_FPGA_RAM_ARB_PERF_EN: saturating transfer
// counters per port and a contention-cycle counter, cleared by PerfClr.
// ---------------------------------------------------------------------------
module soc_fpga_ram_arb #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 14,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  soc_fpga_ram_arb_if.slave      bus
);

  localparam int unsigned DW = DATAWIDTH;
  localparam int unsigned AW = ADDRWIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    RDPEND = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            last_gnt;
  logic            rd_id;
  logic            rd_id_next;
  logic            rvalid0_q;
  logic            rvalid1_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;

  logic            gnt0_c;
  logic            gnt1_c;
  logic            xfer_c;
  logic            win_c;
  logic            win_we_c;
  logic            rd_start_c;
  logic [AW-1:0]   win_addr_c;
  logic [DW-1:0]   win_wdata_c;

  // Arbitration: last_gnt records the previous winner; on contention the
  // other port wins unless fixed priority is selected.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (bus.Req0 && bus.Req1) begin
      if ((FIXED_PRI != 0) || last_gnt) begin
        gnt0_c = 1'b1;
      end else begin
        gnt1_c = 1'b1;
      end
    end else begin
      gnt0_c = bus.Req0;
      gnt1_c = bus.Req1;
    end
  end

  // Winner payload select.
  always_comb begin
    xfer_c      = gnt0_c | gnt1_c;
    win_c       = gnt1_c;
    win_we_c    = win_c ? bus.We1    : bus.We0;
    win_addr_c  = win_c ? bus.Addr1  : bus.Addr0;
    win_wdata_c = win_c ? bus.WData1 : bus.WData0;
    rd_start_c  = xfer_c & ~win_we_c;
  end

  // Read-pending FSM: next state and owner of the read in flight.
  always_comb begin
    state_next = IDLE;
    rd_id_next = rd_id;
    unique case (state)
      IDLE: begin
        if (rd_start_c) begin
          state_next = RDPEND;
          rd_id_next = win_c;
        end
      end
      RDPEND: begin
        if (rd_start_c) begin
          state_next = RDPEND;
          rd_id_next = win_c;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register and registered read-valid pulses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      rd_id     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state     <= state_next;
      rd_id     <= rd_id_next;
      rvalid0_q <= (state_next == RDPEND) && !rd_id_next;
      rvalid1_q <= (state_next == RDPEND) &&  rd_id_next;
    end
  end

  // Last winner and RAM address/data shadow; both hold while idle so the
  // RAM pins do not toggle without a grant.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_gnt <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (xfer_c) begin
      last_gnt <= win_c;
      addr_q   <= win_addr_c;
      wdata_q  <= win_wdata_c;
    end
  end

  assign bus.Gnt0      = gnt0_c;
  assign bus.Gnt1      = gnt1_c;
  assign bus.RamWe     = xfer_c & win_we_c;
  assign bus.RamAddr   = xfer_c ? win_addr_c  : addr_q;
  assign bus.RamDataIn = xfer_c ? win_wdata_c : wdata_q;
  assign bus.RValid0   = rvalid0_q;
  assign bus.RValid1   = rvalid1_q;
  assign bus.RData     = bus.RamDataOut;

`ifdef SOC_FPGA_RAM_ARB_PERF_EN
  localparam int unsigned CNTW = 32;

  logic [CNTW-1:0] gnt_cnt0;
  logic [CNTW-1:0] gnt_cnt1;
  logic [CNTW-1:0] conflict_cnt;

  // Saturating counters; PerfClr wins over any increment in the same cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else if (bus.PerfClr) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0_c && (gnt_cnt0 != '1)) begin
        gnt_cnt0 <= gnt_cnt0 + CNTW'(1);
      end
      if (gnt1_c && (gnt_cnt1 != '1)) begin
        gnt_cnt1 <= gnt_cnt1 + CNTW'(1);
      end
      if (bus.Req0 && bus.Req1 && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNTW'(1);
      end
    end
  end

  assign bus.GntCnt0     = gnt_cnt0;
  assign bus.GntCnt1     = gnt_cnt1;
  assign bus.ConflictCnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_soc_fpga_ram_arb.sv
// ---------------------------------------------------------------------------
// tb_soc_fpga_ram_arb
// Bench for soc_fpga_ram_arb: a round-robin instance backed by a behavioural
// RAM, plus a fixed-priority instance fed the same requests. Expected grants,
// RAM drive and read returns come from a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_soc_fpga_ram_arb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 14;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  always #5 HCLK = ~HCLK;

  soc_fpga_ram_arb_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus_rr ();
  soc_fpga_ram_arb_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus_fp ();

  soc_fpga_ram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .FIXED_PRI(0)) dut_rr (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_rr)
  );

  soc_fpga_ram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .FIXED_PRI(1)) dut_fp (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_fp)
  );

  // Known power-up contents for any word not yet written.
  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    if (a == AW'(16)) return 32'hDEAD_BEEF;
    return (DW'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Behavioural single-port RAM: 1-cycle read, output holds on a write.
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  always @(posedge HCLK) begin
    if (bus_rr.RamWe) begin
      ram_mem[bus_rr.RamAddr] = bus_rr.RamDataIn;
    end else begin
      bus_rr.RamDataOut <= ram_mem.exists(bus_rr.RamAddr) ?
                           ram_mem[bus_rr.RamAddr] : init_word(bus_rr.RamAddr);
    end
  end

  assign bus_fp.RamDataOut = '0;

  // Reference model state
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_pend;
  int            m_pend_id;
  logic [DW-1:0] m_pend_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_addr = '0;
    m_data = '0;
    m_pend = 1'b0;
    m_pend_id = 0;
    m_pend_data = '0;
  endtask

  task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus_rr.Req0 = r0; bus_rr.We0 = w0; bus_rr.Addr0 = a0; bus_rr.WData0 = d0;
    bus_rr.Req1 = r1; bus_rr.We1 = w1; bus_rr.Addr1 = a1; bus_rr.WData1 = d1;
    bus_fp.Req0 = r0; bus_fp.We0 = w0; bus_fp.Addr0 = a0; bus_fp.WData0 = d0;
    bus_fp.Req1 = r1; bus_fp.We1 = w1; bus_fp.Addr1 = a1; bus_fp.WData1 = d1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic adv();
    @(posedge HCLK);
    #1;
  endtask

  // Compare one cycle against the model at the falling edge, then retire it.
  task automatic eval(output bit g0, output bit g1);
    bit            r0, r1, ew;
    int            win, fwin;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge HCLK);
    r0 = bus_rr.Req0;
    r1 = bus_rr.Req1;
    if (r0 && r1) win = (m_last == 1) ? 0 : 1;
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    else          win = -1;
    if (win == 0)      begin ea = bus_rr.Addr0; ed = bus_rr.WData0; ew = bus_rr.We0; end
    else if (win == 1) begin ea = bus_rr.Addr1; ed = bus_rr.WData1; ew = bus_rr.We1; end
    else               begin ea = m_addr;       ed = m_data;        ew = 1'b0;       end
    chk("rr_gnt0",    64'(bus_rr.Gnt0),      64'(win == 0));
    chk("rr_gnt1",    64'(bus_rr.Gnt1),      64'(win == 1));
    chk("rr_ram_we",  64'(bus_rr.RamWe),     64'(ew));
    chk("rr_ram_addr",64'(bus_rr.RamAddr),   64'(ea));
    chk("rr_ram_din", 64'(bus_rr.RamDataIn), 64'(ed));
    chk("rr_rvalid0", 64'(bus_rr.RValid0),   64'(m_pend && m_pend_id == 0));
    chk("rr_rvalid1", 64'(bus_rr.RValid1),   64'(m_pend && m_pend_id == 1));
    if (m_pend) chk("rr_rdata", 64'(bus_rr.RData), 64'(m_pend_data));
    fwin = bus_fp.Req0 ? 0 : (bus_fp.Req1 ? 1 : -1);
    chk("fp_gnt0", 64'(bus_fp.Gnt0), 64'(fwin == 0));
    chk("fp_gnt1", 64'(bus_fp.Gnt1), 64'(fwin == 1));
    m_pend = 1'b0;
    if (win >= 0) begin
      m_last = win;
      m_addr = ea;
      m_data = ed;
      if (ew) begin
        ref_mem[ea] = ed;
      end else begin
        m_pend      = 1'b1;
        m_pend_id   = win;
        m_pend_data = ref_rd(ea);
      end
    end
    g0 = (win == 0);
    g1 = (win == 1);
  endtask

  task automatic do_reset();
    drive_idle();
    #1 HRESETn = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    adv();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return '1;
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit            g0, g1;
    bit            s_r0, s_w0, s_r1, s_w1;
    logic [AW-1:0] s_a0, s_a1;
    logic [DW-1:0] s_d0, s_d1;

`ifdef SOC_FPGA_RAM_ARB_PERF_EN
    bus_rr.PerfClr = 1'b0;
    bus_fp.PerfClr = 1'b0;
`endif
    drive_idle();
    model_reset();

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    chk("reset_rvalid0", 64'(bus_rr.RValid0), 64'(0));
    chk("reset_rvalid1", 64'(bus_rr.RValid1), 64'(0));
    chk("reset_ram_addr",64'(bus_rr.RamAddr), 64'(0));
    chk("reset_ram_we",  64'(bus_rr.RamWe),   64'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    adv();

    // Single read of a preloaded word
    drive(1'b1, 1'b0, AW'(16), '0, 1'b0, 1'b0, '0, '0);
    eval(g0, g1);
    chk("single_gnt0", 64'(bus_rr.Gnt0), 64'(1));
    adv();
    drive_idle();
    eval(g0, g1);
    chk("single_rvalid0", 64'(bus_rr.RValid0), 64'(1));
    chk("single_rdata",   64'(bus_rr.RData),   64'(32'hDEAD_BEEF));
    chk("single_rvalid1", 64'(bus_rr.RValid1), 64'(0));
    adv();

    // Round-robin contention right after reset: 0,1,0,1 with no gaps
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 8), '0);
      eval(g0, g1);
      chk("rr_seq_gnt1", 64'(bus_rr.Gnt1), 64'(i % 2));
      if (i > 0) chk("rr_seq_rvalid1", 64'(bus_rr.RValid1), 64'((i - 1) % 2));
      adv();
    end
    drive_idle();
    eval(g0, g1);
    chk("rr_seq_last_rvalid1", 64'(bus_rr.RValid1), 64'(1));
    adv();

    // Fixed priority: port 0 always wins, port 1 granted once it drops
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, AW'(2), '0, 1'b1, 1'b0, AW'(3), '0);
      eval(g0, g1);
      chk("fp_hold_gnt0", 64'(bus_fp.Gnt0), 64'(1));
      chk("fp_hold_gnt1", 64'(bus_fp.Gnt1), 64'(0));
      adv();
    end
    drive(1'b0, 1'b0, AW'(2), '0, 1'b1, 1'b0, AW'(3), '0);
    eval(g0, g1);
    chk("fp_drop_gnt1", 64'(bus_fp.Gnt1), 64'(1));
    adv();
    drive_idle();
    eval(g0, g1);
    adv();

    // Write to the top address, read it back the next cycle
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'h3FFF, 32'h1234_5678);
    eval(g0, g1);
    chk("wr_ram_we", 64'(bus_rr.RamWe), 64'(1));
    adv();
    drive(1'b1, 1'b0, 14'h3FFF, '0, 1'b0, 1'b0, '0, '0);
    eval(g0, g1);
    chk("rd_ram_we",       64'(bus_rr.RamWe),   64'(0));
    chk("wr_no_rvalid1",   64'(bus_rr.RValid1), 64'(0));
    adv();
    drive_idle();
    eval(g0, g1);
    chk("raw_rvalid0", 64'(bus_rr.RValid0), 64'(1));
    chk("raw_rdata",   64'(bus_rr.RData),   64'(32'h1234_5678));
    adv();

    // Reset while a read is in flight
    drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, '0);
    eval(g0, g1);
    #2;
    HRESETn = 1'b0;
    model_reset();
    drive_idle();
    #1;
    chk("rst_mid_rvalid0_async", 64'(bus_rr.RValid0), 64'(0));
    adv();
    chk("rst_mid_rvalid0", 64'(bus_rr.RValid0), 64'(0));
    chk("rst_mid_rvalid1", 64'(bus_rr.RValid1), 64'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    adv();
    drive(1'b1, 1'b0, AW'(6), '0, 1'b1, 1'b0, AW'(7), '0);
    eval(g0, g1);
    chk("rst_first_gnt0", 64'(bus_rr.Gnt0), 64'(1));
    adv();
    eval(g0, g1);
    chk("rst_second_gnt1", 64'(bus_rr.Gnt1), 64'(1));
    adv();
    drive_idle();
    eval(g0, g1);
    adv();

`ifdef SOC_FPGA_RAM_ARB_PERF_EN
    // Counters: 5 contention cycles, then one lone port-1 request
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, AW'(1), '0, 1'b1, 1'b0, AW'(2), '0);
      eval(g0, g1);
      adv();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(2), '0);
    eval(g0, g1);
    adv();
    drive_idle();
    eval(g0, g1);
    chk("perf_conflict", 64'(bus_rr.ConflictCnt), 64'(5));
    chk("perf_gnt1",     64'(bus_rr.GntCnt1),     64'(3));
    chk("perf_gnt0",     64'(bus_rr.GntCnt0),     64'(3));
    adv();
    // Clear asserted while contending: clear must win over increment
    bus_rr.PerfClr = 1'b1;
    drive(1'b1, 1'b0, AW'(1), '0, 1'b1, 1'b0, AW'(2), '0);
    eval(g0, g1);
    adv();
    bus_rr.PerfClr = 1'b0;
    drive_idle();
    chk("perf_clr_conflict", 64'(bus_rr.ConflictCnt), 64'(0));
    chk("perf_clr_gnt0",     64'(bus_rr.GntCnt0),     64'(0));
    chk("perf_clr_gnt1",     64'(bus_rr.GntCnt1),     64'(0));
    eval(g0, g1);
    adv();
`endif

    // Randomized traffic; a pending request holds its fields until granted
    do_reset();
    s_r0 = 1'b0; s_w0 = 1'b0; s_a0 = '0; s_d0 = '0;
    s_r1 = 1'b0; s_w1 = 1'b0; s_a1 = '0; s_d1 = '0;
    g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!s_r0 || g0) begin
        s_r0 = ($urandom_range(0, 3) != 0);
        s_w0 = ($urandom_range(0, 2) == 0);
        s_a0 = pick_addr();
        s_d0 = $urandom();
      end else if ($urandom_range(0, 7) == 0) begin
        s_r0 = 1'b0;
      end
      if (!s_r1 || g1) begin
        s_r1 = ($urandom_range(0, 3) != 0);
        s_w1 = ($urandom_range(0, 2) == 0);
        s_a1 = pick_addr();
        s_d1 = $urandom();
      end else if ($urandom_range(0, 7) == 0) begin
        s_r1 = 1'b0;
      end
      drive(s_r0, s_w0, s_a0, s_d0, s_r1, s_w1, s_a1, s_d1);
      eval(g0, g1);
      adv();
    end
    drive_idle();
    eval(g0, g1);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
